// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive controller: synchronizes rx, finds the start bit,
// samples each bit at its mid-point and emits each byte with a one-cycle valid pulse.
module uart_rx_ctrl #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned OVS      = 16,
  parameter int unsigned TMR_BITS = 10,
  parameter int unsigned DIVISOR  = 651
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_tick,
  input  logic                rx,
  output logic [TMR_BITS-1:0] final_value,
  output logic                timer_en,
  output logic                rx_busy,
  output logic                rx_done,
  output logic [DBIT-1:0]     rx_data,
  output logic                frame_err
);

  localparam int unsigned SMAX   = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int unsigned SCNT_W = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int unsigned NCNT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SCNT_W-1:0]   s_cnt_q, s_cnt_d;
  logic [NCNT_W-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]     b_q, b_d;
  logic                rx_meta_q, rx_s_q;
  logic                busy_q;
  logic                done_q, done_d;
  logic [DBIT-1:0]     data_q, data_d;
  logic                ferr_q, ferr_d;

  // Timer is configured with a constant terminal count and runs out of reset.
  assign final_value = TMR_BITS'(DIVISOR - 1);
  assign timer_en    = ~rst;

  assign rx_busy   = busy_q;
  assign rx_done   = done_q;
  assign rx_data   = data_q;
  assign frame_err = ferr_q;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    done_d  = 1'b0;
    data_d  = data_q;
    ferr_d  = ferr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end
      // Re-check the line half a bit later to reject glitches.
      ST_START: begin
        if (s_tick) begin
          if (s_cnt_q == SCNT_W'(OVS / 2 - 1)) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SCNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == SCNT_W'(OVS - 1)) begin
            s_cnt_d = '0;
            b_d     = {rx_s_q, b_q[DBIT-1:1]};
            if (n_cnt_q == NCNT_W'(DBIT - 1)) begin
              state_d = ST_STOP;
            end else begin
              n_cnt_d = n_cnt_q + NCNT_W'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SCNT_W'(1);
          end
        end
      end
      // A low stop bit still delivers the byte, flagged as a framing error.
      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SCNT_W'(SB_TICK - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            data_d  = b_q;
            ferr_d  = ~rx_s_q;
          end else begin
            s_cnt_d = s_cnt_q + SCNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames push expected bytes,
// an independent monitor checks every rx_done pulse against the queue.
module tb_uart_rx_ctrl;

  localparam int unsigned DBIT      = 8;
  localparam int unsigned TMR_BITS  = 10;
  localparam int          TICK_DIV  = 4;
  localparam int          BIT_CLKS  = 16 * TICK_DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_tick = 1'b0;
  logic                rx = 1'b1;
  logic [TMR_BITS-1:0] final_value;
  logic                timer_en;
  logic                rx_busy;
  logic                rx_done;
  logic [DBIT-1:0]     rx_data;
  logic                frame_err;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_done = 1'b0;

  uart_rx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .s_tick      (s_tick),
    .rx          (rx),
    .final_value (final_value),
    .timer_en    (timer_en),
    .rx_busy     (rx_busy),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the baud timer: one-clock tick every TICK_DIV clocks.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (cnt == TICK_DIV - 1);
      cnt = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_done must match the oldest expected frame.
  always @(negedge clk) begin
    if (rx_done) begin
      total++;
      if (prev_done) begin
        bad++;
        $display("FAIL done_back_to_back: got two consecutive rx_done cycles expected one");
      end
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got rx_data 0x%0h with no frame expected", rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (rx_data !== e.data) begin
          bad++;
          $display("FAIL rx_data: got 0x%0h expected 0x%0h", rx_data, e.data);
        end
        if (frame_err !== e.ferr) begin
          bad++;
          $display("FAIL frame_err: got %0b expected %0b (data 0x%0h)", frame_err, e.ferr, e.data);
        end
      end
    end
    prev_done = rx_done;
  end

  task automatic hold_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a whole 8N1 frame; abort_bit >= 0 pulses rst partway into that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit);
    if (abort_bit < 0) exp_q.push_back('{data: d, ferr: ~stop});
    rx = 1'b0;
    hold_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        hold_clks(30);
        rx  = 1'b1;
        rst = 1'b1;
        hold_clks(1);
        rst = 1'b0;
        return;
      end
      hold_clks(BIT_CLKS);
    end
    rx = stop;
    // A low stop bit is released early so the line reads idle before any new start check.
    hold_clks(stop ? BIT_CLKS : 40);
    rx = 1'b1;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    rx  = 1'b1;
    hold_clks(3);
    check("reset_busy", 32'(rx_busy), 32'd0);
    check("reset_done", 32'(rx_done), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("final_value", 32'(final_value), 32'd650);
    check("timer_en_in_reset", 32'(timer_en), 32'd0);
    rst = 1'b0;
    hold_clks(1);
    check("timer_en_run", 32'(timer_en), 32'd1);
    hold_clks(20);

    send_frame(8'hA5, 1'b1, -1);
    hold_clks(2 * BIT_CLKS);

    // Short low pulse: start bit rejected at mid-bit check.
    rx = 1'b0;
    hold_clks(10);
    check("glitch_busy_high", 32'(rx_busy), 32'd1);
    hold_clks(4 * TICK_DIV - 10);
    rx = 1'b1;
    hold_clks(BIT_CLKS);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);

    send_frame(8'h3C, 1'b0, -1);
    hold_clks(2 * BIT_CLKS);

    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    hold_clks(2 * BIT_CLKS);

    send_frame(8'h55, 1'b1, 3);
    hold_clks(1);
    check("abort_busy", 32'(rx_busy), 32'd0);
    check("abort_data", 32'(rx_data), 32'd0);
    check("abort_ferr", 32'(frame_err), 32'd0);
    hold_clks(2 * BIT_CLKS);

    send_frame(8'h12, 1'b1, -1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * BIT_CLKS) begin
      hold_clks(1);
      waited++;
    end
    hold_clks(2 * BIT_CLKS);
    check("frames_outstanding", 32'(exp_q.size()), 32'd0);
    check("idle_at_end", 32'(rx_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
